// File: rtl/tmod_arbiter_if.sv
// Command channel between the arbiter and the temperature monitor slave.
// The arbiter drives op/opnd/valid and the monitor returns ready.
interface tmod_arbiter_if #(
    parameter int unsigned OPW = 3,
    parameter int unsigned DW  = 8
);
    logic [OPW-1:0] op;
    logic [DW-1:0]  opnd;
    logic           valid;
    logic           ready;

    modport master (output op, output opnd, output valid, input ready);
    modport slave  (input op, input opnd, input valid, output ready);
endinterface

// File: rtl/tmod_arbiter.sv
// Round-robin arbiter sharing the tmod command channel between N requesters.
// Optional bus_ready timeout abort is enabled by defining TMOD_ARB_TIMEOUT_EN.
module tmod_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned OPW     = 3,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic [N*OPW-1:0] req_op,
    input  logic [N*DW-1:0]  req_data,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     done,
    output logic [N-1:0]     err,
    tmod_arbiter_if.master   bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WW = 8;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;

    if (N < 2 || N > 8 || TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_param
        $error("tmod_arbiter: unsupported N or TIMEOUT");
    end

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    done_q, done_d;
    logic [N-1:0]    err_q, err_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [DW-1:0]   opnd_q, opnd_d;
    logic            valid_q, valid_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic [OPW-1:0]  op_sel;
    logic [DW-1:0]   data_sel;
    logic [IW-1:0]   win_next;

    // First requester at or after the pointer; scanning backwards lets the lowest offset win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = IW'((32'(ptr_q) + 32'(i)) % N);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        op_sel   = '0;
        data_sel = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (IW'(i) == pick_idx) begin
                op_sel   = req_op[i*OPW +: OPW];
                data_sel = req_data[i*DW +: DW];
            end
        end
    end

    assign win_next = (win_q == IW'(N - 1)) ? '0 : IW'(win_q + 1'b1);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        err_d      = '0;
        op_d       = op_q;
        opnd_d     = opnd_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    win_d  = pick_idx;
                    op_d   = op_sel;
                    opnd_d = data_sel;
                    for (int i = 0; i < int'(N); i++) begin
                        gnt_d[i] = (IW'(i) == pick_idx);
                    end
                    if (op_sel != '0) begin
                        valid_d    = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (valid_q && bus.ready) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end
`ifdef TMOD_ARB_TIMEOUT_EN
                else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                    // Monitor never accepted: abort with err instead of done.
                    valid_d = 1'b0;
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    op_d    = '0;
                    opnd_d  = '0;
                    ptr_d   = win_next;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = WW'(wait_cnt_q + 1'b1);
                end
`endif
            end
            S_DONE: begin
                done_d  = gnt_q;
                gnt_d   = '0;
                op_d    = '0;
                opnd_d  = '0;
                ptr_d   = win_next;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            op_q       <= '0;
            opnd_q     <= '0;
            valid_q    <= 1'b0;
            ptr_q      <= '0;
            win_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            valid_q    <= valid_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign bus.op    = op_q;
    assign bus.opnd  = opnd_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_tmod_arbiter.sv
// Directed bench for tmod_arbiter: reset, single transfer, round-robin order,
// ready stall, NOOP path and the bus_ready timeout (both builds).
module tb_tmod_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned OPW = 3;
    localparam int unsigned DW  = 8;
    localparam logic [OPW-1:0] NOOP    = 3'd0;
    localparam logic [OPW-1:0] SET_FRQ = 3'd2;
    localparam logic [OPW-1:0] RD_TMP  = 3'd5;

    logic             clk;
    logic             reset_n;
    logic [N-1:0]     req;
    logic [N*OPW-1:0] req_op;
    logic [N*DW-1:0]  req_data;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic [N-1:0]     err;

    int unsigned errors;
    int unsigned checks;

    tmod_arbiter_if #(.OPW(OPW), .DW(DW)) bus_if ();

    tmod_arbiter #(.N(N), .OPW(OPW), .DW(DW), .TIMEOUT(64)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_op   (req_op),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [OPW-1:0] op, input logic [DW-1:0] data);
        req_op[i*OPW +: OPW] = op;
        req_data[i*DW +: DW] = data;
        req[i]               = 1'b1;
    endtask

    task automatic check_bus(input string tag, input logic [N-1:0] g, input logic v,
                             input logic [OPW-1:0] op, input logic [DW-1:0] opnd);
        check({tag, "_gnt"}, 32'(gnt), 32'(g));
        check({tag, "_valid"}, 32'(bus_if.valid), 32'(v));
        check({tag, "_op"}, 32'(bus_if.op), 32'(op));
        check({tag, "_opnd"}, 32'(bus_if.opnd), 32'(opnd));
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset_n      = 1'b0;
        req          = '0;
        req_op       = '0;
        req_data     = '0;
        bus_if.ready = 1'b0;
        repeat (3) step();
        check_bus("reset", 4'b0000, 1'b0, NOOP, 8'h00);
        check("reset_done", 32'(done), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        reset_n = 1'b1;
        step();

        // Single request on index 2 with ready already high.
        set_req(2, SET_FRQ, 8'h3C);
        bus_if.ready = 1'b1;
        step();
        check_bus("single_grant", 4'b0100, 1'b1, SET_FRQ, 8'h3C);
        check("single_grant_done", 32'(done), 32'h0);
        step();
        check("single_xfer_valid", 32'(bus_if.valid), 32'h0);
        check("single_xfer_done", 32'(done), 32'h0);
        step();
        check("single_done", 32'(done), 32'b0100);
        check("single_done_gnt", 32'(gnt), 32'h0);
        check("single_done_op", 32'(bus_if.op), 32'(NOOP));
        req[2] = 1'b0;
        step();
        check("single_after_done", 32'(done), 32'h0);
        check("single_after_gnt", 32'(gnt), 32'h0);

        // Stall: ready low 10 cycles, operand change after grant must be ignored.
        bus_if.ready = 1'b0;
        set_req(0, RD_TMP, 8'hA5);
        step();
        check_bus("stall_grant", 4'b0001, 1'b1, RD_TMP, 8'hA5);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) req_data[0*DW +: DW] = 8'h5A;
            if (c == 5) req_op[0*OPW +: OPW] = SET_FRQ;
            step();
            check_bus($sformatf("stall_hold%0d", c), 4'b0001, 1'b1, RD_TMP, 8'hA5);
            check($sformatf("stall_nodone%0d", c), 32'(done), 32'h0);
        end
        bus_if.ready = 1'b1;
        step();
        check("stall_xfer_valid", 32'(bus_if.valid), 32'h0);
        check("stall_xfer_done", 32'(done), 32'h0);
        step();
        check("stall_done", 32'(done), 32'b0001);
        req[0] = 1'b0;

        // Reset asserted mid-ISSUE drops valid and grant without a done.
        bus_if.ready = 1'b0;
        set_req(3, SET_FRQ, 8'h11);
        step();
        check_bus("rst_grant", 4'b1000, 1'b1, SET_FRQ, 8'h11);
        step();
        check("rst_issue_valid", 32'(bus_if.valid), 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(bus_if.valid), 32'h0);
        check("rst_async_gnt", 32'(gnt), 32'h0);
        check("rst_async_done", 32'(done), 32'h0);
        req = '0;
        step();
        step();
        check("rst_held_done", 32'(done), 32'h0);
        reset_n = 1'b1;
        step();
        check("rst_release_done", 32'(done), 32'h0);

        // All four requesting with ready high: order 0,1,2,3,0, 3 cycles apart.
        bus_if.ready = 1'b1;
        for (int i = 0; i < int'(N); i++) set_req(i, 3'(i + 1), 8'(8'h40 + i));
        for (int n = 0; n < 5; n++) begin
            step();
            check_bus($sformatf("rr_grant%0d", n), 4'(1 << (n % 4)), 1'b1,
                      3'((n % 4) + 1), 8'(8'h40 + (n % 4)));
            step();
            check($sformatf("rr_xfer_done%0d", n), 32'(done), 32'h0);
            step();
            check($sformatf("rr_done%0d", n), 32'(done), 32'(1 << (n % 4)));
            check($sformatf("rr_done_gnt%0d", n), 32'(gnt), 32'h0);
        end
        req = '0;
        step();
        check("rr_idle_gnt", 32'(gnt), 32'h0);

        // NOOP on requester 1 (pointer now 1): grant one cycle, no bus activity.
        set_req(1, NOOP, 8'h77);
        step();
        check("noop_grant", 32'(gnt), 32'b0010);
        check("noop_grant_valid", 32'(bus_if.valid), 32'h0);
        step();
        check("noop_done", 32'(done), 32'b0010);
        check("noop_done_gnt", 32'(gnt), 32'h0);
        check("noop_done_valid", 32'(bus_if.valid), 32'h0);
        req[1] = 1'b0;
        step();
        check("noop_after_done", 32'(done), 32'h0);

        // Ready stuck low with requesters 2 and 3 pending (pointer now 2).
        bus_if.ready = 1'b0;
        set_req(2, SET_FRQ, 8'h22);
        set_req(3, RD_TMP, 8'h33);
        step();
        check_bus("to_grant", 4'b0100, 1'b1, SET_FRQ, 8'h22);
`ifdef TMOD_ARB_TIMEOUT_EN
        repeat (63) step();
        check("to_pre_valid", 32'(bus_if.valid), 32'h1);
        check("to_pre_err", 32'(err), 32'h0);
        step();
        check("to_err", 32'(err), 32'b0100);
        check("to_err_valid", 32'(bus_if.valid), 32'h0);
        check("to_err_gnt", 32'(gnt), 32'h0);
        check("to_err_done", 32'(done), 32'h0);
        req[2] = 1'b0;
        step();
        check("to_err_clear", 32'(err), 32'h0);
        check_bus("to_next", 4'b1000, 1'b1, RD_TMP, 8'h33);
        bus_if.ready = 1'b1;
        step();
        step();
        check("to_next_done", 32'(done), 32'b1000);
        req[3] = 1'b0;
`else
        repeat (70) step();
        check_bus("to_hold", 4'b0100, 1'b1, SET_FRQ, 8'h22);
        check("to_hold_err", 32'(err), 32'h0);
        bus_if.ready = 1'b1;
        step();
        check("to_late_xfer", 32'(bus_if.valid), 32'h0);
        step();
        check("to_late_done", 32'(done), 32'b0100);
        check("to_late_err", 32'(err), 32'h0);
        req[2] = 1'b0;
        step();
        check_bus("to_next", 4'b1000, 1'b1, RD_TMP, 8'h33);
        step();
        step();
        check("to_next_done", 32'(done), 32'b1000);
        req[3] = 1'b0;
`endif
        step();
        check("final_gnt", 32'(gnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
